// File: rtl/emif_status_pkg.sv
// rtl/emif_status_pkg.sv - shared state, status encodings and width helper for the EMIF status monitor
package emif_status_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_CAL_WAIT     = 3'd1,
    ST_TG_WAIT      = 3'd2,
    ST_DONE_PASS    = 3'd3,
    ST_DONE_FAIL    = 3'd4,
    ST_DONE_TIMEOUT = 3'd5
  } state_e;

  localparam logic [1:0] CH_PEND = 2'b00;
  localparam logic [1:0] CH_CAL  = 2'b01;
  localparam logic [1:0] CH_PASS = 2'b10;
  localparam logic [1:0] CH_FAIL = 2'b11;

  function automatic int ch_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/emif_status_prio_enc.sv
// rtl/emif_status_prio_enc.sv - lowest-index priority encoder with valid flag
module emif_status_prio_enc #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req_i,
  output logic         valid_o,
  output logic [W-1:0] idx_o
);

  // Scan downwards so the lowest set bit is the last one to win.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = W'(i);
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/emif_status_monitor.sv
// rtl/emif_status_monitor.sv - multi-channel calibration / traffic-generator verdict monitor
module emif_status_monitor
  import emif_status_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CAL_TIMEOUT = 100000,
  parameter int TG_TIMEOUT  = 1000000,
  parameter int CNT_W       = 32,
  localparam int IDX_W      = ch_idx_w(NUM_CH)
) (
  input  logic                emif_usr_clk,
  input  logic                emif_usr_reset_n,
  input  logic                start,
  input  logic                clear,
  input  logic [NUM_CH-1:0]   ch_enable,
  input  logic [NUM_CH-1:0]   cal_success,
  input  logic [NUM_CH-1:0]   cal_fail,
  input  logic [NUM_CH-1:0]   tg_pass,
  input  logic [NUM_CH-1:0]   tg_fail,
  input  logic [NUM_CH-1:0]   tg_timeout,
  output logic                busy,
  output logic                cal_success_all,
  output logic                cal_fail_any,
  output logic                traffic_gen_pass,
  output logic                traffic_gen_fail,
  output logic                traffic_gen_timeout,
  output logic [IDX_W-1:0]    fail_ch,
  output logic [2*NUM_CH-1:0] ch_status,
  output logic [CNT_W-1:0]    elapsed_cycles
);

  localparam logic [CNT_W-1:0] CAL_LAST = CNT_W'(CAL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TG_LAST  = CNT_W'(TG_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]    phase_q, phase_d;
  logic [CNT_W-1:0]    elapsed_q, elapsed_d;
  logic                busy_q, busy_d;
  logic                cal_all_q, cal_all_d;
  logic                cal_fail_any_q, cal_fail_any_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic                tmo_q, tmo_d;
  logic [IDX_W-1:0]    fail_ch_q, fail_ch_d;
  logic [2*NUM_CH-1:0] status_q, status_d;

  logic [NUM_CH-1:0] cal_ok, cal_bad, tg_ok, tg_bad, tg_to, passed_now;
  logic              cal_bad_v, tg_bad_v, tg_to_v;
  logic [IDX_W-1:0]  cal_bad_idx, tg_bad_idx, tg_to_idx;

  assign cal_ok  = cal_success & mask_q;
  assign cal_bad = cal_fail & mask_q;
  assign tg_ok   = tg_pass & mask_q;
  assign tg_bad  = (cal_fail | tg_fail) & mask_q;
  assign tg_to   = tg_timeout & mask_q;

  emif_status_prio_enc #(.N(NUM_CH), .W(IDX_W)) u_enc_cal_fail (
    .req_i(cal_bad), .valid_o(cal_bad_v), .idx_o(cal_bad_idx)
  );
  emif_status_prio_enc #(.N(NUM_CH), .W(IDX_W)) u_enc_tg_fail (
    .req_i(tg_bad), .valid_o(tg_bad_v), .idx_o(tg_bad_idx)
  );
  emif_status_prio_enc #(.N(NUM_CH), .W(IDX_W)) u_enc_tg_tmo (
    .req_i(tg_to), .valid_o(tg_to_v), .idx_o(tg_to_idx)
  );

  // A channel counts as passed if its sticky pass is already recorded or it passes now.
  always_comb begin
    passed_now = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      passed_now[i] = mask_q[i] & (tg_pass[i] | (status_q[2*i +: 2] == CH_PASS));
    end
  end

  always_comb begin
    state_d        = state_q;
    mask_d         = mask_q;
    phase_d        = phase_q;
    elapsed_d      = elapsed_q;
    cal_all_d      = cal_all_q;
    cal_fail_any_d = cal_fail_any_q;
    pass_d         = pass_q;
    fail_d         = fail_q;
    tmo_d          = tmo_q;
    fail_ch_d      = fail_ch_q;
    status_d       = status_q;

    if (busy_q && (elapsed_q != '1)) elapsed_d = elapsed_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d = ch_enable;
          if (|ch_enable) begin
            state_d   = ST_CAL_WAIT;
            phase_d   = '0;
            elapsed_d = '0;
          end
        end
      end
      ST_CAL_WAIT: begin
        phase_d = phase_q + 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
          if (cal_ok[i]) status_d[2*i +: 2] = CH_CAL;
        end
        if (cal_bad_v) begin
          state_d        = ST_DONE_FAIL;
          cal_fail_any_d = 1'b1;
          fail_d         = 1'b1;
          fail_ch_d      = cal_bad_idx;
          for (int i = 0; i < NUM_CH; i++) begin
            if (cal_bad[i]) status_d[2*i +: 2] = CH_FAIL;
          end
        end else if (&(cal_ok | ~mask_q)) begin
          state_d   = ST_TG_WAIT;
          cal_all_d = 1'b1;
          phase_d   = '0;
        end else if (phase_q == CAL_LAST) begin
          state_d   = ST_DONE_TIMEOUT;
          tmo_d     = 1'b1;
          fail_ch_d = '0;
        end
      end
      ST_TG_WAIT: begin
        phase_d = phase_q + 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
          if (tg_ok[i]) status_d[2*i +: 2] = CH_PASS;
        end
        if (tg_bad_v) begin
          state_d        = ST_DONE_FAIL;
          fail_d         = 1'b1;
          cal_fail_any_d = |cal_bad;
          fail_ch_d      = tg_bad_idx;
          for (int i = 0; i < NUM_CH; i++) begin
            if (tg_bad[i]) status_d[2*i +: 2] = CH_FAIL;
          end
        end else if (tg_to_v) begin
          state_d   = ST_DONE_TIMEOUT;
          tmo_d     = 1'b1;
          fail_ch_d = tg_to_idx;
        end else if (&(passed_now | ~mask_q)) begin
          state_d = ST_DONE_PASS;
          pass_d  = 1'b1;
        end else if (phase_q == TG_LAST) begin
          state_d   = ST_DONE_TIMEOUT;
          tmo_d     = 1'b1;
          fail_ch_d = '0;
        end
      end
      default: ;
    endcase

    if (clear) begin
      state_d        = ST_IDLE;
      mask_d         = '0;
      phase_d        = '0;
      elapsed_d      = '0;
      cal_all_d      = 1'b0;
      cal_fail_any_d = 1'b0;
      pass_d         = 1'b0;
      fail_d         = 1'b0;
      tmo_d          = 1'b0;
      fail_ch_d      = '0;
      status_d       = '0;
    end

    busy_d = (state_d == ST_CAL_WAIT) || (state_d == ST_TG_WAIT);
  end

  always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
    if (!emif_usr_reset_n) begin
      state_q        <= ST_IDLE;
      mask_q         <= '0;
      phase_q        <= '0;
      elapsed_q      <= '0;
      busy_q         <= 1'b0;
      cal_all_q      <= 1'b0;
      cal_fail_any_q <= 1'b0;
      pass_q         <= 1'b0;
      fail_q         <= 1'b0;
      tmo_q          <= 1'b0;
      fail_ch_q      <= '0;
      status_q       <= '0;
    end else begin
      state_q        <= state_d;
      mask_q         <= mask_d;
      phase_q        <= phase_d;
      elapsed_q      <= elapsed_d;
      busy_q         <= busy_d;
      cal_all_q      <= cal_all_d;
      cal_fail_any_q <= cal_fail_any_d;
      pass_q         <= pass_d;
      fail_q         <= fail_d;
      tmo_q          <= tmo_d;
      fail_ch_q      <= fail_ch_d;
      status_q       <= status_d;
    end
  end

  assign busy                = busy_q;
  assign cal_success_all     = cal_all_q;
  assign cal_fail_any        = cal_fail_any_q;
  assign traffic_gen_pass    = pass_q;
  assign traffic_gen_fail    = fail_q;
  assign traffic_gen_timeout = tmo_q;
  assign fail_ch             = fail_ch_q;
  assign ch_status           = status_q;
  assign elapsed_cycles      = elapsed_q;

endmodule

// File: tb/tb_emif_status_monitor.sv
// tb/tb_emif_status_monitor.sv - directed-vector bench for emif_status_monitor (2- and 4-channel)
module tb_emif_status_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start_a = 0, clear_a = 0;
  logic [1:0] en_a = 0, cs_a = 0, cf_a = 0, tp_a = 0, tf_a = 0, tt_a = 0;
  logic       busy_a, csa_a, cfa_a, pass_a, fail_a, to_a;
  logic [0:0] fch_a;
  logic [3:0] st_a;
  logic [15:0] el_a;

  logic       start_b = 0, clear_b = 0;
  logic [3:0] en_b = 0, cs_b = 0, cf_b = 0, tp_b = 0, tf_b = 0, tt_b = 0;
  logic       busy_b, csa_b, cfa_b, pass_b, fail_b, to_b;
  logic [1:0] fch_b;
  logic [7:0] st_b;
  logic [15:0] el_b;

  emif_status_monitor #(.NUM_CH(2), .CAL_TIMEOUT(8), .TG_TIMEOUT(64), .CNT_W(16)) u_dut_a (
    .emif_usr_clk(clk), .emif_usr_reset_n(rst_n), .start(start_a), .clear(clear_a),
    .ch_enable(en_a), .cal_success(cs_a), .cal_fail(cf_a), .tg_pass(tp_a), .tg_fail(tf_a),
    .tg_timeout(tt_a), .busy(busy_a), .cal_success_all(csa_a), .cal_fail_any(cfa_a),
    .traffic_gen_pass(pass_a), .traffic_gen_fail(fail_a), .traffic_gen_timeout(to_a),
    .fail_ch(fch_a), .ch_status(st_a), .elapsed_cycles(el_a)
  );

  emif_status_monitor #(.NUM_CH(4), .CAL_TIMEOUT(16), .TG_TIMEOUT(64), .CNT_W(16)) u_dut_b (
    .emif_usr_clk(clk), .emif_usr_reset_n(rst_n), .start(start_b), .clear(clear_b),
    .ch_enable(en_b), .cal_success(cs_b), .cal_fail(cf_b), .tg_pass(tp_b), .tg_fail(tf_b),
    .tg_timeout(tt_b), .busy(busy_b), .cal_success_all(csa_b), .cal_fail_any(cfa_b),
    .traffic_gen_pass(pass_b), .traffic_gen_fail(fail_b), .traffic_gen_timeout(to_b),
    .fail_ch(fch_b), .ch_status(st_b), .elapsed_cycles(el_b)
  );

  int vec_cnt = 0;
  int miss_cnt = 0;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic quiet_a();
    start_a = 0; clear_a = 0; cs_a = 0; cf_a = 0; tp_a = 0; tf_a = 0; tt_a = 0;
  endtask

  task automatic clear_dut_a();
    quiet_a();
    clear_a = 1;
    step(1);
    clear_a = 0;
    check_vec("a_clear_flags", {busy_a, csa_a, cfa_a, pass_a, fail_a, to_a}, 6'b0);
    check_vec("a_clear_status", {fch_a, st_a, el_a}, 21'h0);
  endtask

  // flags order: {busy, cal_success_all, cal_fail_any, pass, fail, timeout}
  logic [15:0] el_snap;

  initial begin
    step(2);
    check_vec("a_reset_flags", {busy_a, csa_a, cfa_a, pass_a, fail_a, to_a}, 6'b0);
    check_vec("a_reset_status", {fch_a, st_a, el_a}, 21'h0);
    check_vec("b_reset_flags", {busy_b, csa_b, cfa_b, pass_b, fail_b, to_b}, 6'b0);
    check_vec("b_reset_status", {fch_b, st_b, el_b}, 26'h0);
    rst_n = 1;
    step(1);

    // Full pass on both channels with a sticky pass on ch0.
    en_a = 2'b11; start_a = 1;
    step(1);
    start_a = 0;
    check_vec("p_busy_entry", {busy_a, el_a}, {1'b1, 16'd0});
    step(4);
    cs_a = 2'b11;
    step(1);
    check_vec("p_cal_all", {busy_a, csa_a, st_a}, {1'b1, 1'b1, 4'b0101});
    step(15);
    tp_a = 2'b01;
    step(1);
    tp_a = 2'b00;
    check_vec("p_ch0_pass", {busy_a, pass_a, st_a}, {1'b1, 1'b0, 4'b0110});
    step(9);
    check_vec("p_sticky", st_a, 4'b0110);
    tp_a = 2'b10;
    step(1);
    check_vec("p_done_pass", {busy_a, csa_a, cfa_a, pass_a, fail_a, to_a}, 6'b010100);
    check_vec("p_status", st_a, 4'b1010);
    check_vec("p_elapsed", el_a, 16'd31);
    el_snap = el_a;
    start_a = 1;
    step(3);
    start_a = 0;
    check_vec("p_frozen", {pass_a, el_a}, {1'b1, el_snap});
    clear_dut_a();

    // Calibration timeout of 8 cycles.
    en_a = 2'b11; start_a = 1;
    step(1);
    start_a = 0;
    step(7);
    check_vec("t_before", {busy_a, to_a}, 2'b10);
    step(1);
    check_vec("t_timeout", {busy_a, csa_a, cfa_a, pass_a, fail_a, to_a}, 6'b000001);
    check_vec("t_fail_ch", {fch_a, el_a}, {1'b0, 16'd8});
    clear_dut_a();

    // Disabled ch1 fails, enabled ch0 passes.
    en_a = 2'b01; cs_a = 2'b01; start_a = 1;
    step(1);
    start_a = 0;
    step(1);
    check_vec("m_cal", {busy_a, csa_a, st_a}, {1'b1, 1'b1, 4'b0001});
    tp_a = 2'b01; tf_a = 2'b10;
    step(1);
    check_vec("m_pass", {busy_a, pass_a, fail_a, st_a}, {1'b0, 1'b1, 1'b0, 4'b0010});
    clear_dut_a();

    // ch0 passes then fails before ch1 passes.
    en_a = 2'b11; start_a = 1;
    step(1);
    start_a = 0; cs_a = 2'b11;
    step(1);
    tp_a = 2'b01;
    step(1);
    check_vec("f_ch0_pass", st_a, 4'b0110);
    tp_a = 2'b00; tf_a = 2'b01;
    step(1);
    check_vec("f_done", {busy_a, csa_a, cfa_a, pass_a, fail_a, to_a}, 6'b010010);
    check_vec("f_ch_status", {fch_a, st_a}, {1'b0, 4'b0111});
    clear_dut_a();

    // 4-channel: simultaneous cal_fail on ch3 and ch1 picks ch1.
    en_b = 4'b1011; start_b = 1;
    step(1);
    start_b = 0;
    check_vec("b_busy", busy_b, 1'b1);
    cf_b = 4'b1010;
    step(1);
    cf_b = 4'b0000;
    check_vec("b_done_fail", {busy_b, csa_b, cfa_b, pass_b, fail_b, to_b}, 6'b001010);
    check_vec("b_fail_ch", fch_b, 2'd1);
    check_vec("b_status", {st_b[3:2], st_b[5:4]}, 4'b1100);

    // Asynchronous reset in the middle of the traffic phase.
    en_a = 2'b11; start_a = 1;
    step(1);
    start_a = 0; cs_a = 2'b11;
    step(1);
    tp_a = 2'b01;
    step(1);
    check_vec("r_in_tg", {busy_a, csa_a, st_a}, {1'b1, 1'b1, 4'b0110});
    #2 rst_n = 0;
    #1;
    check_vec("r_async_flags", {busy_a, csa_a, cfa_a, pass_a, fail_a, to_a}, 6'b0);
    check_vec("r_async_status", {fch_a, st_a, el_a}, 21'h0);
    check_vec("r_async_b", {fail_b, cfa_b, fch_b, st_b}, 12'h0);
    quiet_a();
    @(negedge clk);
    rst_n = 1;
    step(1);

    // start and clear together from idle; start with an empty mask.
    en_a = 2'b11; start_a = 1; clear_a = 1;
    step(1);
    start_a = 0; clear_a = 0;
    check_vec("s_clear_wins", {busy_a, el_a}, 17'h0);
    en_a = 2'b00; start_a = 1;
    step(1);
    start_a = 0;
    step(1);
    check_vec("s_empty_mask", {busy_a, to_a, pass_a}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/emif_status_monitor.md
# emif_status_monitor

Multi-channel calibration and traffic-generator status monitor for the EMIF example-design simulation and hardware checker path. It watches per-channel calibration and traffic-generator flags from `NUM_CH` memory interfaces and enforces its own calibration and traffic timeouts. It reduces them to one sticky pass/fail/timeout verdict, with the first failing channel index and per-channel status. It sits between the EMIF/traffic-generator instances and the top-level checker outputs, replacing the single-channel checker flags.

## Interface
- `NUM_CH`, 2: monitored channels, 1..16.
- `CAL_TIMEOUT`, 100000: cycles allowed in calibration wait; must be ≥ 1.
- `TG_TIMEOUT`, 1000000: cycles allowed in traffic wait; must be ≥ 1.
- `CNT_W`, 32: width of the cycle counter. `2**CNT_W` must exceed both timeouts.
- `emif_usr_clk  in  1`: sole clock.
- `emif_usr_reset_n  in  1`: asynchronous, active-low reset.
- `start  in  1`: single-cycle pulse that arms the monitor.
- `clear  in  1`: single-cycle pulse that aborts or clears the result and returns to idle.
- `ch_enable  in  NUM_CH`: channel mask, sampled on accepted `start`.
- `cal_success`, `cal_fail`  `in  NUM_CH`: per-channel calibration levels.
- `tg_pass`, `tg_fail`, `tg_timeout`  `in  NUM_CH`: per-channel traffic-generator levels.
- `busy  out  1`: high in the wait states.
- `cal_success_all  out  1`: all enabled channels calibrated.
- `cal_fail_any  out  1`: a calibration failure ended the run.
- `traffic_gen_pass`, `traffic_gen_fail`, `traffic_gen_timeout`  `out  1`: final verdict. These are mutually exclusive and sticky.
- `fail_ch  out  max(1,$clog2(NUM_CH))`: lowest-index enabled channel that caused FAIL or TIMEOUT. It is 0 for a monitor timeout.
- `ch_status  out  2*NUM_CH`: per-channel status. Encoding: 00 pending, 01 calibrated, 10 passed, 11 failed.
- `elapsed_cycles  out  CNT_W`: cycles since accepted `start`. Saturates at all-ones and freezes in the DONE states.

## Operation
- States: `IDLE`, `CAL_WAIT`, `TG_WAIT`, `DONE_PASS`, `DONE_FAIL`, `DONE_TIMEOUT`.
- `clear` in any state: go to `IDLE` and zero all flags, status, `fail_ch` and counters. `clear` beats `start` in the same cycle.
- `IDLE` + `start`: latch `ch_enable` into the mask.
  - Mask all-zero: `start` is ignored and the state stays `IDLE`.
  - Otherwise go to `CAL_WAIT`, zero the phase counter and `elapsed_cycles`.
- `CAL_WAIT` transitions, in priority order:
  1. Any enabled `cal_fail` → `DONE_FAIL`. Set `cal_fail_any` and `traffic_gen_fail`. Set that channel's status to 11 and `fail_ch` to the lowest such index.
  2. All enabled `cal_success` → `TG_WAIT`. Set `cal_success_all` and the enabled statuses to 01. Zero the phase counter.
  3. Phase counter = `CAL_TIMEOUT-1` → `DONE_TIMEOUT`, with `traffic_gen_timeout` set and `fail_ch` = 0.
- Per-channel status in `CAL_WAIT`: a channel showing `cal_success` before the others moves to 01.
- `TG_WAIT` behaviour:
  - Per-channel sticky pass: enabled `tg_pass` sets status 10, and it stays 10 even if `tg_pass` later drops.
  - Transitions, in priority order, all using the lowest index among enabled channels:
    1. Enabled `cal_fail` or `tg_fail` → `DONE_FAIL`.
    2. Enabled `tg_timeout` → `DONE_TIMEOUT`, with `fail_ch` set.
    3. All enabled channels passed, counting channels passing in this same cycle → `DONE_PASS`.
    4. Phase counter = `TG_TIMEOUT-1` → `DONE_TIMEOUT`, with `fail_ch` = 0.
  - A channel whose sticky pass is already set can still fail. A fail overrides its status to 11 and the verdict is `DONE_FAIL`.
- Disabled channels: inputs are ignored and status stays 00.
- `DONE_*`: all outputs hold. `start` is ignored; only `clear` or reset leaves.

## Timing
- All outputs are registered. A flag sampled at edge N is reflected in outputs after edge N, a 1-cycle latency.
- Reset: state `IDLE`; every output 0, including `fail_ch`, `ch_status` and `elapsed_cycles`.
- Reset asserted mid-run aborts immediately. There is no resumption.
- The phase counter starts at 0 on the cycle after entry.
  - `CAL_TIMEOUT=k` with no calibration: `traffic_gen_timeout` rises exactly k cycles after `CAL_WAIT` is entered.
  - The same rule applies to `TG_TIMEOUT` in `TG_WAIT`.
- `elapsed_cycles` increments every cycle while `busy`.
- `busy` is high for exactly the `CAL_WAIT` and `TG_WAIT` cycles.

## Structure
- Shared package `emif_status_pkg`:
  - state enum
  - `ch_status` encoding constants `CH_PEND`, `CH_CAL`, `CH_PASS`, `CH_FAIL`
  - index-width function `ch_idx_w(NUM_CH)`
- Sub-module `emif_status_prio_enc`: parametrised lowest-index priority encoder, giving a valid bit and an index. It is used for all `fail_ch` selection.

## Test plan
- `NUM_CH=2`, mask 11, both `cal_success` at cycle 5, `tg_pass` ch0 at cycle 20 and ch1 at cycle 30 → `traffic_gen_pass` after cycle 30; `ch_status`=1010; `elapsed_cycles` frozen.
- `NUM_CH=4`, mask 1011, `cal_fail` on ch3 and ch1 in the same cycle → `DONE_FAIL`, `cal_fail_any`=1, `fail_ch`=1.
- `CAL_TIMEOUT=8`, no calibration → `traffic_gen_timeout` exactly 8 cycles after `CAL_WAIT` entry; `fail_ch`=0; `busy` falls in the same cycle.
- Mask 01, ch1 asserts `tg_fail` and ch0 passes → `DONE_PASS`, ch1 status 00.
- ch0 passes, then asserts `tg_fail` before ch1 passes → `DONE_FAIL`, `fail_ch`=0, ch0 status 11.
- Reset asserted mid-`TG_WAIT` → all outputs 0 asynchronously. `start`+`clear` in the same cycle from `IDLE` → stays `IDLE`.
